// File: rtl/gf180mcu_osu_sc_gp12t3v3__sipo_deser.sv
// Serial-in/parallel-out deserializer: WIDTH bits -> word, with one-cycle VALID strobe.
// Optional even-parity check on each completed word when GF180_SIPO_PARITY_EN is defined.
module gf180mcu_osu_sc_gp12t3v3__sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RN,
    input  logic                       EN,
    input  logic                       D,
    input  logic                       CLR,
`ifdef GF180_SIPO_PARITY_EN
    input  logic                       PAR,
    output logic                       PERR,
`endif
    output logic [WIDTH-1:0]           Q,
    output logic                       VALID,
    output logic [$clog2(WIDTH)-1:0]   CNT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    // The same shifted value serves as next SR on a middle bit and as the
    // completed word on the final bit, so {SR,D} ordering is automatic.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], D};
        end else begin
            shifted = {D, sr_q[WIDTH-1:1]};
        end
    end

    assign last_bit = (cnt_q == CNT_LAST);

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = 1'b0;
        if (CLR) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (EN) begin
            if (!last_bit) begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
            end else begin
                q_d     = shifted;
                valid_d = 1'b1;
                sr_d    = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign CNT   = cnt_q;

`ifdef GF180_SIPO_PARITY_EN
    logic perr_q, perr_d;

    // Updated only alongside a completed word; CLR leaves it alone.
    always_comb begin
        perr_d = perr_q;
        if (!CLR && EN && last_bit) begin
            perr_d = ^{shifted, PAR};
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__sipo_deser.sv
// Directed bench for the SIPO deserializer: MSB-first and LSB-first instances share stimulus.
// Parity checks are included when GF180_SIPO_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_gf180mcu_osu_sc_gp12t3v3__sipo_deser;

    logic       clk;
    logic       rn;
    logic       en;
    logic       d;
    logic       clr;
    logic [7:0] q_m,   q_l;
    logic       vld_m, vld_l;
    logic [2:0] cnt_m, cnt_l;
`ifdef GF180_SIPO_PARITY_EN
    logic       par;
    logic       perr_m, perr_l;
`endif

    int n_checks;
    int n_fail;

    gf180mcu_osu_sc_gp12t3v3__sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .CLK   (clk),
        .RN    (rn),
        .EN    (en),
        .D     (d),
        .CLR   (clr),
`ifdef GF180_SIPO_PARITY_EN
        .PAR   (par),
        .PERR  (perr_m),
`endif
        .Q     (q_m),
        .VALID (vld_m),
        .CNT   (cnt_m)
    );

    gf180mcu_osu_sc_gp12t3v3__sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .CLK   (clk),
        .RN    (rn),
        .EN    (en),
        .D     (d),
        .CLR   (clr),
`ifdef GF180_SIPO_PARITY_EN
        .PAR   (par),
        .PERR  (perr_l),
`endif
        .Q     (q_l),
        .VALID (vld_l),
        .CNT   (cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        en = 1'b1;
        d  = b;
        tick();
        en = 1'b0;
    endtask

    // Sends the first seven bits of an MSB-first word; caller handles bit 0.
    task automatic send_msb7(input logic [7:0] w);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
    endtask

    int vcount;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rn  = 1'b0;
        en  = 1'b0;
        d   = 1'b0;
        clr = 1'b0;
`ifdef GF180_SIPO_PARITY_EN
        par = 1'b0;
`endif
        repeat (2) tick();
        check_eq("rst_q",     q_m,   8'h00);
        check_eq("rst_valid", vld_m, 1'b0);
        check_eq("rst_cnt",   cnt_m, 3'd0);
`ifdef GF180_SIPO_PARITY_EN
        check_eq("rst_perr",  perr_m, 1'b0);
`endif
        #4 rn = 1'b1;

        // Word A5, MSB first
        send_msb7(8'hA5);
        check_eq("a5_no_early_valid", vld_m, 1'b0);
        check_eq("a5_cnt7",           cnt_m, 3'd7);
        send_bit(1'b1);
        check_eq("a5_q",     q_m,   8'hA5);
        check_eq("a5_valid", vld_m, 1'b1);
        check_eq("a5_cnt0",  cnt_m, 3'd0);
        tick();
        check_eq("a5_valid_one_cycle", vld_m, 1'b0);
        check_eq("a5_q_held",          q_m,   8'hA5);

        // Asynchronous reset mid-word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rn = 1'b0;
        #1;
        check_eq("arst_q",     q_m,   8'h00);
        check_eq("arst_valid", vld_m, 1'b0);
        check_eq("arst_cnt",   cnt_m, 3'd0);
        #1 rn = 1'b1;
        vcount = 0;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
            if (vld_m) vcount++;
        end
        check_eq("arst_no_valid_7bits", vcount, 0);
        send_bit(1'b0);
        check_eq("arst_valid_8th", vld_m, 1'b1);
        check_eq("arst_q_fe",      q_m,   8'hFE);

        // Word 3C with a 3-cycle EN gap after bit 4
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("gap_cnt4", cnt_m, 3'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("gap_cnt_hold", cnt_m, 3'd4);
            check_eq("gap_no_valid", vld_m, 1'b0);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("gap_q_old", q_m, 8'hFE);
        send_bit(1'b0);
        check_eq("gap_q",     q_m,   8'h3C);
        check_eq("gap_valid", vld_m, 1'b1);

        // Partial word discarded by CLR (with EN high)
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check_eq("clr_cnt5", cnt_m, 3'd5);
        clr = 1'b1; en = 1'b1; d = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        check_eq("clr_cnt0",  cnt_m, 3'd0);
        check_eq("clr_valid", vld_m, 1'b0);
        check_eq("clr_q_held", q_m,  8'h3C);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        check_eq("clr_q_ff",     q_m,   8'hFF);
        check_eq("clr_valid_ff", vld_m, 1'b1);

        // CLR on the final-bit cycle wins
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        clr = 1'b1; en = 1'b1; d = 1'b0;
        tick();
        clr = 1'b0; en = 1'b0;
        check_eq("clr_final_no_valid", vld_m, 1'b0);
        check_eq("clr_final_q_held",   q_m,   8'hFF);
        check_eq("clr_final_cnt0",     cnt_m, 3'd0);

        // LSB-first instance: 03 then back-to-back 80
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        check_eq("lsb_q03",    q_l,   8'h03);
        check_eq("lsb_valid",  vld_l, 1'b1);
        check_eq("lsb_msb_q",  q_m,   8'hC0);
        en = 1'b1;
        vcount = 0;
        for (int i = 0; i < 7; i++) begin
            d = 1'b0;
            tick();
            if (vld_l) vcount++;
        end
        check_eq("lsb_b2b_no_early_valid", vcount, 0);
        check_eq("lsb_cnt7", cnt_l, 3'd7);
        d = 1'b1;
        tick();
        en = 1'b0;
        check_eq("lsb_q80",       q_l,   8'h80);
        check_eq("lsb_b2b_valid", vld_l, 1'b1);
        check_eq("lsb_cnt0",      cnt_l, 3'd0);

`ifdef GF180_SIPO_PARITY_EN
        send_msb7(8'h07);
        par = 1'b0;
        send_bit(1'b1);
        check_eq("par_q07",   q_m,    8'h07);
        check_eq("par_err1",  perr_m, 1'b1);
        tick();
        check_eq("par_hold",  perr_m, 1'b1);
        send_msb7(8'h07);
        par = 1'b1;
        send_bit(1'b1);
        par = 1'b0;
        check_eq("par_err0",  perr_m, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
